// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM for the single-ALU CPU datapath
module multicycle_ctrl #(
    parameter int WAIT_W     = 8,
    parameter int WAIT_LIMIT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ack,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       tgt_we,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_op,
    output logic [2:0] alu_ctrl,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5
    } state_t;

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

    state_t            cur;
    state_t            nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;
    logic              timeout;
    logic              is_addu, is_subu, is_ori, is_lw, is_sw, is_beq, supported;

    assign is_addu   = (opcode == 6'b000000) && (funct == 6'b100001);
    assign is_subu   = (opcode == 6'b000000) && (funct == 6'b100011);
    assign is_ori    = (opcode == 6'b001101);
    assign is_lw     = (opcode == 6'b100011);
    assign is_sw     = (opcode == 6'b101011);
    assign is_beq    = (opcode == 6'b000100);
    assign supported = is_addu | is_subu | is_ori | is_lw | is_sw | is_beq;

    // An ack in the limit cycle wins, so timeout requires mem_ack low.
    assign waiting = ((cur == FETCH) || (cur == MEM)) && !mem_ack;
    assign timeout = waiting && (wait_cnt == LIMIT);
    assign state   = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // FETCH->FETCH on timeout is not a state change, so clear explicitly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if ((nxt != cur) || timeout) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        nxt        = IDLE;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        tgt_we     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        alu_ctrl   = 3'b000;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        case (cur)
            IDLE: nxt = FETCH;
            FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = 3'b001;
                nxt       = FETCH;
                if (mem_ack) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = DECODE;
                end else if (timeout) begin
                    bus_err = 1'b1;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = 3'b001;
                tgt_we    = 1'b1;
                if (supported) begin
                    nxt = EXEC;
                end else begin
                    illegal = 1'b1;
                    nxt     = FETCH;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                nxt       = FETCH;
                if (is_addu) begin
                    alu_ctrl = 3'b001;
                    nxt      = WB;
                end else if (is_subu) begin
                    alu_ctrl = 3'b011;
                    nxt      = WB;
                end else if (is_ori) begin
                    alu_src_b = 2'b10;
                    alu_ctrl  = 3'b010;
                    nxt       = WB;
                end else if (is_lw || is_sw) begin
                    alu_src_b = 2'b10;
                    ext_op    = 1'b1;
                    alu_ctrl  = is_lw ? 3'b110 : 3'b111;
                    nxt       = MEM;
                end else if (is_beq) begin
                    alu_ctrl = 3'b101;
                    pc_we    = alu_zero;
                    pc_src   = alu_zero;
                end
            end
            MEM: begin
                nxt = FETCH;
                if (is_lw || is_sw) begin
                    mem_rd = is_lw;
                    mem_wr = is_sw;
                    if (mem_ack) begin
                        nxt = is_lw ? WB : FETCH;
                    end else if (timeout) begin
                        bus_err = 1'b1;
                    end else begin
                        nxt = MEM;
                    end
                end
            end
            WB: begin
                reg_we     = 1'b1;
                reg_dst    = is_addu | is_subu;
                mem_to_reg = is_lw;
                nxt        = FETCH;
            end
            default: nxt = IDLE;
        endcase
    end

endmodule
